right_shift_pipelined: RTL and testbench
========================================

# right_shift_pipelined

- Pipelined barrel right shifter with valid/ready flow control.
- Undoes a left shift of the same operand: it restores alignment after the search datapath has left-aligned a word, and it extracts high fields.
- Resolves the shift amount two bits per stage, most-significant digit first, so logic depth per stage is one 4:1 mux.
- Supports logical (zero-fill) or arithmetic (sign-fill) mode; backpressure stalls the pipeline without losing or reordering data.

## Interface
- WIDTH, 13: operand width in bits.
- STAGES, 2: number of pipeline stages (latency). The maximum representable shift is 4^STAGES − 1.
- ARITH, 0: 0 selects zero fill; 1 selects sign fill (replicates in[WIDTH-1]).
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word and shift amount are present.
- in_ready  out  1  block accepts the input this cycle.
- in  in  WIDTH  operand.
- shift  in  $clog2(WIDTH)  right-shift amount.
- out_valid  out  1  out holds a result.
- out_ready  in  1  downstream accepts the result this cycle.
- out  out  WIDTH  shifted result.

## Operation
- Elaboration check: $clog2(WIDTH) ≤ 2*STAGES, otherwise $error. The operand is padded to PADDED_WIDTH = 4^STAGES bits, with fill bits placed above the MSB.
- Stage s (s = STAGES−1 down to 0, entry stage s = STAGES−1) takes shift digit d = shift[2s+1:2s] and shifts right by d·4^s.
  - Vacated bits take the fill value: 0, or the sign bit captured at entry when ARITH=1.
- Each stage register holds: data (PADDED_WIDTH bits), the remaining shift digits still to be applied, the fill bit, and a valid bit.
- Stage s advances when its valid bit is set and the downstream slot is free or emptying.
  - Downstream slot for stage 0 is out_ready.
  - The advance term is computed combinationally from the output back to the input, so bubbles collapse.
- in_ready = !valid[STAGES−1] || advance[STAGES−1]. An input is accepted on in_valid && in_ready.
- out = stage-0 data[WIDTH-1:0]; out_valid = valid[0].
- A stage that does not advance holds its contents unchanged.
- Shift amounts ≥ WIDTH (possible when WIDTH is not a power of 2) yield all-fill: zero, or all-ones for a negative operand with ARITH=1.
- shift = 0 passes the operand through unchanged.
- A result is emitted exactly once; order is preserved.

## Timing
- Reset (asynchronous, on reset_n low): all valid bits 0, all data, shift and fill registers 0.
  - Outputs while reset_n is low: out_valid=0, out=0, in_ready=1.
- A reset asserted mid-operation discards every in-flight word. After reset_n rises, the first accepted word appears after STAGES cycles.
- Latency with out_ready held high: a word accepted at edge t is presented with out_valid=1 after edge t+STAGES−1. Total STAGES register stages, including the output register.
- Throughput: one word per cycle while out_ready=1.
- Backpressure:
  - While out_ready=0 with out_valid=1, out and out_valid hold stable.
  - Upstream stages keep filling until all STAGES slots are valid; in_ready then falls combinationally in the same cycle.
- Simultaneous accept and emit on a full pipeline is permitted: in_ready=1 when out_ready=1.
- in_ready depends combinationally on out_ready; it has no dependence on in_valid.

## Structure
- Shared header right_shift_defs.vh provides:
  - PADDED_WIDTH(STAGES) and SHIFT_BITS(WIDTH) macros, reused with the left shifter.
  - FILL_ZERO/FILL_SIGN constants.
- Sub-module right_shift_radix4_stage: combinational 4:1 right shift by d·4^s with fill input. The top level instantiates it STAGES times in a generate loop and owns all registers and the flow-control logic.

## Test plan
- WIDTH=13, STAGES=2, ARITH=0, out_ready=1: in=13'h1FFF, shift=5 → out=13'h00FF with out_valid, 2 cycles after acceptance; a back-to-back word with shift=0 appears the next cycle unchanged.
- ARITH=1: in=13'h1000, shift=12 → 13'h1FFF. in=13'h0FFF, shift=4 → 13'h00FF.
- shift=13, 14, 15 with in=13'h1ABC, ARITH=0 → out=0. Same inputs with ARITH=1 → 13'h1FFF.
- Backpressure: stream words 1..6 with shift=1 while out_ready is low for 4 cycles.
  - in_ready falls after 2 accepted words, and out holds 13'h0000 (1>>1) stable throughout.
  - Releasing out_ready yields 0,1,1,2,2,3 in order with no loss or duplication.
- Random valid/ready stimulus, 10k words, checked against a reference model of (in >> shift) with fill; scoreboard compares order and values.
- Assert reset_n low for 1 cycle with 2 words in flight → out_valid=0 immediately, in_ready=1, no stale word emitted afterward. The next word emerges with latency 2.

Source files
------------

// File: rtl/right_shift_pipelined_pkg.sv
// Shared definitions for the pipelined radix-4 right shifter: fill modes and
// width helpers that the left shifter reuses as well.
package right_shift_pipelined_pkg;

    typedef enum logic {
        FILL_ZERO = 1'b0,
        FILL_SIGN = 1'b1
    } fill_mode_e;

    // Operand is padded to a power of four so every stage shifts by whole digits.
    function automatic int padded_width(input int stages);
        return 1 << (2 * stages);
    endfunction

    function automatic int shift_bits(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/right_shift_pipelined_if.sv
// Valid/ready bundle between a producer, the shifter and its consumer.
interface right_shift_pipelined_if #(
    parameter int WIDTH = 13
) ();
    import right_shift_pipelined_pkg::*;

    localparam int SHIFT_W = shift_bits(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in;
    logic [SHIFT_W-1:0] shift;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out;

    modport master (
        output in_valid, in, shift, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, shift, out_ready,
        output in_ready, out_valid, out
    );

endinterface

// File: rtl/right_shift_pipelined_radix4_stage.sv
// One radix-4 digit of the barrel shifter: right shift by digit * 4^STAGE,
// vacated positions take the fill bit. Purely combinational, one 4:1 mux deep.
module right_shift_pipelined_radix4_stage #(
    parameter int PW    = 16,
    parameter int STAGE = 0
) (
    input  logic [PW-1:0] data_in,
    input  logic [1:0]    digit,
    input  logic          fill,
    output logic [PW-1:0] data_out
);
    localparam int UNIT  = 1 << (2 * STAGE);
    localparam int EXT_W = PW + 3 * UNIT;

    logic [EXT_W-1:0] ext;
    logic [PW-1:0]    cand [4];

    assign ext = {{(3 * UNIT){fill}}, data_in};

    for (genvar k = 0; k < 4; k++) begin : g_cand
        assign cand[k] = ext[k * UNIT +: PW];
    end

    // Select the candidate matching this stage's shift digit.
    always_comb begin
        data_out = cand[digit];
    end

endmodule

// File: rtl/right_shift_pipelined.sv
// Pipelined barrel right shifter with valid/ready flow control. The shift
// amount is resolved two bits per stage, most-significant digit at entry.
// Shift amounts >= WIDTH reach into the padding and so yield all-fill.
module right_shift_pipelined
    import right_shift_pipelined_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int STAGES = 2,
    parameter int ARITH  = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    right_shift_pipelined_if.slave bus
);
    localparam int PW = padded_width(STAGES);
    localparam int SW = shift_bits(WIDTH);
    localparam int DW = 2 * STAGES;
    localparam fill_mode_e FILL_MODE = (ARITH != 0) ? FILL_SIGN : FILL_ZERO;

    if (SW > DW) begin : g_bad_cfg
        $error("right_shift_pipelined: shift width %0d exceeds %0d digit bits", SW, DW);
    end

    logic [DW-1:0]              shift_ext;
    logic                       fill_in;
    logic [PW-1:0]              data_in_pad;
    logic [PW-1:0]              stage_out [STAGES];
    logic [STAGES-1:0][PW-1:0]  data_q;
    logic [STAGES-1:0][DW-1:0]  shift_q;
    logic [STAGES-1:0]          fill_q;
    logic [STAGES-1:0]          valid_q;
    logic [STAGES-1:0]          adv;
    logic                       in_ready_w;
    logic                       accept;
    logic                       unused_bits;

    assign shift_ext = DW'(bus.shift);
    assign fill_in   = (FILL_MODE == FILL_SIGN) ? bus.in[WIDTH-1] : 1'b0;

    // Pad the operand with fill bits above the MSB up to a power-of-four width.
    always_comb begin
        data_in_pad              = {PW{fill_in}};
        data_in_pad[WIDTH-1:0]   = bus.in;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == STAGES - 1) begin : g_entry
            right_shift_pipelined_radix4_stage #(.PW(PW), .STAGE(s)) u_stage (
                .data_in  (data_in_pad),
                .digit    (shift_ext[2*s +: 2]),
                .fill     (fill_in),
                .data_out (stage_out[s])
            );
        end else begin : g_mid
            right_shift_pipelined_radix4_stage #(.PW(PW), .STAGE(s)) u_stage (
                .data_in  (data_q[s+1]),
                .digit    (shift_q[s+1][2*s +: 2]),
                .fill     (fill_q[s+1]),
                .data_out (stage_out[s])
            );
        end
    end

    // Advance terms ripple from the output back toward the input so bubbles collapse.
    always_comb begin
        logic room;
        adv  = '0;
        room = bus.out_ready;
        for (int s = 0; s < STAGES; s++) begin
            adv[s] = valid_q[s] && room;
            room   = !valid_q[s] || adv[s];
        end
    end

    assign in_ready_w = !valid_q[STAGES-1] || adv[STAGES-1];
    assign accept     = bus.in_valid && in_ready_w;

    // Stage registers: load from upstream when a word moves in, drain when it only moves out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            shift_q <= '0;
            fill_q  <= '0;
            valid_q <= '0;
        end else begin
            if (accept) begin
                valid_q[STAGES-1] <= 1'b1;
                data_q[STAGES-1]  <= stage_out[STAGES-1];
                shift_q[STAGES-1] <= shift_ext;
                fill_q[STAGES-1]  <= fill_in;
            end else if (adv[STAGES-1]) begin
                valid_q[STAGES-1] <= 1'b0;
            end
            for (int s = 0; s < STAGES - 1; s++) begin
                if (adv[s+1]) begin
                    valid_q[s] <= 1'b1;
                    data_q[s]  <= stage_out[s];
                    shift_q[s] <= shift_q[s+1];
                    fill_q[s]  <= fill_q[s+1];
                end else if (adv[s]) begin
                    valid_q[s] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = valid_q[0];
    assign bus.out       = data_q[0][WIDTH-1:0];

    // Padding above WIDTH, spent digits and the last fill bit are never read.
    assign unused_bits = ^{data_q[0], shift_q, fill_q[0]};

endmodule

// File: tb/tb_right_shift_pipelined.sv
// Directed and random checks of the pipelined right shifter. Two instances
// (zero fill and sign fill) share identical stimulus and flow control.
module tb_right_shift_pipelined;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [12:0] in_w = '0;
    logic [3:0]  shift_w = '0;

    always #5 clk = ~clk;

    right_shift_pipelined_if #(.WIDTH(13)) bus_z ();
    right_shift_pipelined_if #(.WIDTH(13)) bus_s ();

    assign bus_z.in_valid  = in_valid;
    assign bus_z.in        = in_w;
    assign bus_z.shift     = shift_w;
    assign bus_z.out_ready = out_ready;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.in        = in_w;
    assign bus_s.shift     = shift_w;
    assign bus_s.out_ready = out_ready;

    right_shift_pipelined #(.WIDTH(13), .STAGES(2), .ARITH(0)) u_dut_z (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_z)
    );

    right_shift_pipelined #(.WIDTH(13), .STAGES(2), .ARITH(1)) u_dut_s (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_s)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [12:0] q_z [$];
    logic [12:0] q_s [$];
    logic        acc, rdy, ov;
    logic [12:0] oz;

    typedef struct packed {
        logic [12:0] d;
        logic [3:0]  sh;
        logic [12:0] ez;
        logic [12:0] es;
    } vec_t;

    vec_t tbl [12] = '{
        '{13'h1FFF, 4'd5,  13'h00FF, 13'h1FFF},
        '{13'h1000, 4'd12, 13'h0001, 13'h1FFF},
        '{13'h0FFF, 4'd4,  13'h00FF, 13'h00FF},
        '{13'h1ABC, 4'd13, 13'h0000, 13'h1FFF},
        '{13'h1ABC, 4'd14, 13'h0000, 13'h1FFF},
        '{13'h1ABC, 4'd15, 13'h0000, 13'h1FFF},
        '{13'h1ABC, 4'd0,  13'h1ABC, 13'h1ABC},
        '{13'h1ABC, 4'd4,  13'h01AB, 13'h1FAB},
        '{13'h0ABC, 4'd3,  13'h0157, 13'h0157},
        '{13'h1555, 4'd7,  13'h002A, 13'h1FEA},
        '{13'h1001, 4'd1,  13'h0800, 13'h1800},
        '{13'h0001, 4'd12, 13'h0000, 13'h0000}
    };

    logic [12:0] bp_exp [6] = '{13'h0000, 13'h0001, 13'h0001, 13'h0002, 13'h0002, 13'h0003};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] model(input logic [12:0] a, input logic [3:0] sh, input bit arith);
        logic signed [12:0] sa;
        sa = a;
        if (sh >= 4'd13) return (arith && a[12]) ? 13'h1FFF : 13'h0000;
        if (arith) return sa >>> sh;
        return a >> sh;
    endfunction

    // One clock: drive at the falling edge, sample shortly after, score, wait for next falling edge.
    task automatic step(input logic iv, input logic [12:0] d, input logic [3:0] sh,
                        input logic [12:0] ez, input logic [12:0] es, input logic ordy,
                        output logic a, output logic r, output logic v, output logic [12:0] o);
        in_valid  = iv;
        in_w      = d;
        shift_w   = sh;
        out_ready = ordy;
        #1;
        a = iv && bus_z.in_ready;
        r = bus_z.in_ready;
        v = bus_z.out_valid;
        o = bus_z.out;
        if (bus_z.out_valid && ordy) begin
            if (q_z.size() == 0) begin
                check("spurious_out", bus_z.out_valid, 1'b0);
            end else begin
                check("out_zero_fill", bus_z.out, q_z.pop_front());
                check("out_sign_fill", bus_s.out, q_s.pop_front());
                check("out_valid_sign", bus_s.out_valid, 1'b1);
            end
        end
        if (a) begin
            q_z.push_back(ez);
            q_s.push_back(es);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && q_z.size() != 0; c++)
            step(1'b0, '0, '0, '0, '0, 1'b1, acc, rdy, ov, oz);
        check("drain_empty", q_z.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n_acc;
        logic        iv_r, or_r;
        logic [12:0] d_r;
        logic [3:0]  sh_r;

        // Reset state
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", bus_z.out_valid, 1'b0);
        check("rst_out", bus_z.out, 13'h0000);
        check("rst_in_ready", bus_z.in_ready, 1'b1);
        check("rst_out_valid_s", bus_s.out_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Latency and back-to-back
        step(1'b1, 13'h1FFF, 4'd5, 13'h00FF, 13'h1FFF, 1'b1, acc, rdy, ov, oz);
        check("lat_accept", acc, 1'b1);
        check("lat_after_t", bus_z.out_valid, 1'b0);
        step(1'b1, 13'h0ABC, 4'd0, 13'h0ABC, 13'h0ABC, 1'b1, acc, rdy, ov, oz);
        check("lat_after_t1", bus_z.out_valid, 1'b1);
        check("lat_value", bus_z.out, 13'h00FF);
        step(1'b0, '0, '0, '0, '0, 1'b1, acc, rdy, ov, oz);
        check("b2b_valid", bus_z.out_valid, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b1, acc, rdy, ov, oz);
        check("idle_valid", bus_z.out_valid, 1'b0);

        // Directed vector table at full throughput
        idx = 0;
        for (int c = 0; c < 40 && idx < 12; c++) begin
            step(1'b1, tbl[idx].d, tbl[idx].sh, tbl[idx].ez, tbl[idx].es, 1'b1, acc, rdy, ov, oz);
            if (acc) idx++;
        end
        check("table_accepted", idx, 12);
        drain();

        // Backpressure: out_ready low for the first 4 cycles
        idx = 1;
        for (int c = 0; c < 30 && idx <= 6; c++) begin
            step(1'b1, 13'(idx), 4'd1, bp_exp[idx-1], bp_exp[idx-1], (c >= 4), acc, rdy, ov, oz);
            if (c < 2) check("bp_ready_early", rdy, 1'b1);
            if (c == 2) check("bp_accepted_before_full", idx - 1, 2);
            if (c == 2 || c == 3) check("bp_ready_low", rdy, 1'b0);
            if (c >= 2 && c <= 4) begin
                check("bp_hold_valid", ov, 1'b1);
                check("bp_hold_out", oz, 13'h0000);
            end
            if (acc) idx++;
        end
        check("bp_all_accepted", idx, 7);
        drain();

        // Random valid/ready against the reference model
        n_acc = 0;
        for (int c = 0; c < 40000 && n_acc < 10000; c++) begin
            iv_r = ($urandom_range(0, 99) < 70);
            or_r = ($urandom_range(0, 99) < 70);
            d_r  = 13'($urandom);
            sh_r = 4'($urandom);
            step(iv_r, d_r, sh_r, model(d_r, sh_r, 1'b0), model(d_r, sh_r, 1'b1), or_r, acc, rdy, ov, oz);
            if (acc) n_acc++;
        end
        check("rand_words", n_acc, 10000);
        drain();

        // Reset with two words in flight
        step(1'b1, 13'h0123, 4'd2, 13'h0048, 13'h0048, 1'b0, acc, rdy, ov, oz);
        step(1'b1, 13'h0456, 4'd2, 13'h0115, 13'h0115, 1'b0, acc, rdy, ov, oz);
        check("inflight_valid", bus_z.out_valid, 1'b1);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("midrst_out_valid", bus_z.out_valid, 1'b0);
        check("midrst_in_ready", bus_z.in_ready, 1'b1);
        check("midrst_out", bus_z.out, 13'h0000);
        check("midrst_out_valid_s", bus_s.out_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        q_z.delete();
        q_s.delete();
        for (int c = 0; c < 4; c++) begin
            step(1'b0, '0, '0, '0, '0, 1'b1, acc, rdy, ov, oz);
            check("midrst_no_stale", ov, 1'b0);
        end
        step(1'b1, 13'h1ABC, 4'd4, 13'h01AB, 13'h1FAB, 1'b1, acc, rdy, ov, oz);
        check("postrst_accept", acc, 1'b1);
        check("postrst_after_t", bus_z.out_valid, 1'b0);
        step(1'b0, '0, '0, '0, '0, 1'b1, acc, rdy, ov, oz);
        check("postrst_after_t1", bus_z.out_valid, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
